nibble_serial_add_seq: RTL and testbench
========================================

Name: nibble_serial_add_seq

Overview:
- Sequencer that drives one shared 4-bit ripple adder nibble-by-nibble to add or subtract wide operands.
- Latches operands on a valid/ready handshake and walks nibble 0..NIBBLES-1, one per clock, through the 4-bit adder.
- Keeps the inter-nibble carry in a register and presents the assembled result on an output valid/ready handshake.
- Sits between the CPU control path and the 4-bit adder datapath, trading latency for adder area.

Parameters:
- NIBBLES, 4: operand width in nibbles (W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request carries a valid operation.
- in_ready  out  1  block can accept a request.
- op_sub  in  1  0 = add (A+B+cin), 1 = subtract (A-B; cin ignored).
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry in; add only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- cout  out  1  carry out of the MSB nibble; for subtract, 1 = no borrow.

Behaviour:
- Clock and reset: one clock clk; reset rst_n asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, nibble index=0, carry reg=0, operand regs=0.
- Reset mid-operation: asserting rst_n low in any state aborts immediately to the reset values; the partial result is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clock edge: latch a into A_r; latch b into B_r, bitwise inverted when op_sub=1.
  - Seed carry reg with op_sub ? 1 : cin. Set index=0, clear result, go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the adder sees A_r[4i+3:4i], B_r[4i+3:4i], carry reg, where i = index.
  - At the edge, store the sum in result[4i+3:4i] and the adder C4 into carry reg.
  - If i==NIBBLES-1: load cout from C4 and go to DONE; otherwise i++.
- State DONE:
  - out_valid=1; result and cout are held stable.
  - On out_ready, return to IDLE.
  - in_ready=0 in DONE, so there is no accept on the same edge as out_ready.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge. Throughput is one op per NIBBLES+2 cycles minimum.
- Backpressure:
  - out_ready low in DONE holds all outputs indefinitely.
  - Inputs a, b, op_sub, cin are don't-care outside the accepting edge.
  - out_ready is ignored outside DONE.
- Arithmetic: modulo 2^W. cout = bit W of A + B_eff + seed. The index counter is max(1, clog2(NIBBLES)) bits and never wraps past NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle; behaviour is otherwise identical.

Optional Feature:
- Macro: NIBSEQ_FLAGS_EN.
- Defined: adds outputs zero (1 bit) and ovf (1 bit).
  - zero = (result == 0).
  - ovf = signed overflow = (A_r[W-1] == B_r[W-1]) & (result[W-1] != A_r[W-1]), using B_r as effectively added.
  - Both registered with cout on entry to DONE. Reset value 0. Held in DONE.
- Undefined: the zero and ovf ports and their logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package nibseq_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparam NIBBLE_W=4.
  - function for index width (max(1, clog2(n))).
- One sub-module, nibble_add4:
  - Purely combinational 4-bit adder with ports A, B, C0, S, C4.
  - Instantiated once.
  - Holds no state; all sequencing stays in the parent.

Test Plan:
- Add, NIBBLES=4: a=0x1234, b=0x0FCD, cin=0 -> after 4 cycles out_valid=1, result=0x2201, cout=0.
- Carry chain through all nibbles: a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> result=0x0000, cout=1.
- Subtract: a=0x0005, b=0x0007, op_sub=1, cin=1 -> result=0xFFFE, cout=0 (borrow); cin must have no effect. a=0x0007, b=0x0005 -> result=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/cout stable, in_ready=0, an in_valid pulse is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN:
  - Drop rst_n 2 cycles after accepting 0xAAAA+0x5555 -> asynchronously all outputs at reset values, in_ready=1.
  - A new op 0x0001+0x0001 then yields 0x0002 with correct latency.
- Flags (NIBSEQ_FLAGS_EN):
  - 0x7FFF+0x0001 -> ovf=1, zero=0.
  - 0x8000-0x8000 -> result=0x0000, zero=1, ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_add_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | nibseq_pkg : shared types and constants for the nibble-serial adder      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package nibseq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index: max(1, clog2(n)).
    function automatic int idx_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_add_seq_add4.sv
// +--------------------------------------------------------------------------+
// | nibble_add4 : combinational 4-bit ripple-carry adder                     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module nibble_add4
    import nibseq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                C0,
    output logic [NIBBLE_W-1:0] S,
    output logic                C4
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = C0;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign C4 = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_seq.sv
// +--------------------------------------------------------------------------+
// | nibble_serial_add_seq : wide add/subtract through one shared 4-bit adder |
// | Optional zero/ovf flag outputs when NIBSEQ_FLAGS_EN is defined.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module nibble_serial_add_seq
    import nibseq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    result,
`ifdef NIBSEQ_FLAGS_EN
    output logic                    zero,
    output logic                    ovf,
`endif
    output logic                    cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic [IW-1:0]      r_idx;
    logic               r_carry;
    logic               r_cout;

    logic [IW+1:0]          w_off;
    logic [NIBBLE_W-1:0]    w_sum;
    logic                   w_c4;
    logic [W-1:0]           w_res_next;
    logic                   w_accept;
    logic                   w_last;

    assign w_off    = {r_idx, 2'b00};
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == IW'(NIBBLES - 1));

    nibble_add4 u_add4 (
        .A  (r_a[w_off +: NIBBLE_W]),
        .B  (r_b[w_off +: NIBBLE_W]),
        .C0 (r_carry),
        .S  (w_sum),
        .C4 (w_c4)
    );

    // Result with the current nibble merged in; also feeds the flag logic.
    always_comb begin
        w_res_next = r_result;
        w_res_next[w_off +: NIBBLE_W] = w_sum;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1, so invert B and force the seed carry.
            r_a      <= a;
            r_b      <= op_sub ? ~b : b;
            r_carry  <= op_sub | cin;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_res_next;
            r_carry  <= w_c4;
            if (w_last) begin
                r_cout <= w_c4;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

`ifdef NIBSEQ_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_zero <= (w_res_next == '0);
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_res_next[W-1] != r_a[W-1]);
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_seq.sv
// +--------------------------------------------------------------------------+
// | tb_nibble_serial_add_seq : self-checking bench for nibble_serial_add_seq |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_nibble_serial_add_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           op_sub = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           cin = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   result;
    logic           cout;
`ifdef NIBSEQ_FLAGS_EN
    logic           zero;
    logic           ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_serial_add_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef NIBSEQ_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain wide arithmetic; subtract ignores cin.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic sub, input logic mc,
                         output logic [W-1:0] er, output logic ec,
                         output logic ez, output logic eo);
        longint sa, sb, sr;
        longint ua, ub, ur;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end else begin
            ur = ua + ub + longint'(mc);
            sr = sa + sb + longint'(mc);
            ec = (ur >= (longint'(1) << W));
        end
        er = W'(ur);
        ez = (er == '0);
        eo = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic sub, input logic tc, input string tag);
        logic [W-1:0] er;
        logic ec, ez, eo;
        int lat;
        model(ta, tb, sub, tc, er, ec, ez, eo);
        @(negedge clk);
        a = ta; b = tb; op_sub = sub; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op_sub = $urandom; cin = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(N));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef NIBSEQ_FLAGS_EN
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rdy"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [W-1:0] held;
        logic held_c;

        #12;
        chk("rst_state", 64'({in_ready, out_valid, cout, result}), {46'd0, 2'b10, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "add1");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "chain1");
        do_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, "chain2");
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow_c1");
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow_c0");
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, "sub_noborrow");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_add");
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, "zero_sub");
        chk("zero_sub_value", 64'(result), 64'h0);

        // Backpressure: DONE holds while out_ready is low, ignores in_valid.
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; op_sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("bp_valid", 64'(out_valid), 64'd1);
        held = result;
        held_c = cout;
        chk("bp_value", 64'(held), 64'h0407);
        @(negedge clk);
        a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 64'({out_valid, in_ready, cout, result}),
                64'({1'b1, 1'b0, held_c, held}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", 64'({out_valid, in_ready}), 64'b01);

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst", 64'({in_ready, out_valid, cout, result}), {46'd0, 2'b10, 1'b0, 16'h0});
        @(posedge clk);
        #1;
        chk("midrun_rst_hold", 64'({in_ready, out_valid}), 64'b10);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, "post_rst");

        for (int k = 0; k < 20; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
